// File: rtl/sa_sched_pkg.sv
// Shared types and sizing helpers for the systolic-array round-robin scheduler.
package sa_sched_pkg;

  localparam int MAT_W = 16 * 16 * 16;
  localparam int IDX_W = $clog2(4);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  function automatic int mat_w(input int r, input int c, input int d);
    return r * c * d;
  endfunction

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr_i, with wrap.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    // i runs 1..N_REQ so the last-granted requester is checked last
    for (int i = 1; i <= N_REQ; i++) begin
      j = (int'(ptr_i) + i) % N_REQ;
      if (!vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sa_rr_scheduler.sv
// Shares one systolic-array engine among N_REQ requesters, round-robin.
// Optional watchdog on the engine result enabled by SA_SCHED_WATCHDOG_EN.
module sa_rr_scheduler
  import sa_sched_pkg::*;
#(
  parameter int D_W   = 16,
  parameter int SA_R  = 16,
  parameter int SA_C  = 16,
  parameter int N_REQ = 4
`ifdef SA_SCHED_WATCHDOG_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic                                I_CLK,
  input  logic                                I_ASYN_RSTN,
  input  logic [N_REQ-1:0]                    I_REQ,
  input  logic [N_REQ*SA_R*SA_C*D_W-1:0]      I_X_MATRIX,
  input  logic [N_REQ*SA_R*SA_C*D_W-1:0]      I_W_MATRIX,
  output logic [N_REQ-1:0]                    O_GNT,
  output logic [N_REQ-1:0]                    O_DONE,
  output logic [SA_R*SA_C*D_W-1:0]            O_OUT,
  output logic                                O_BUSY,
  output logic                                O_SA_START,
  output logic                                O_SA_SYNC_RSTN,
  output logic [SA_R*SA_C*D_W-1:0]            O_SA_X_MATRIX,
  output logic [SA_R*SA_C*D_W-1:0]            O_SA_W_MATRIX,
`ifdef SA_SCHED_WATCHDOG_EN
  output logic                                O_TIMEOUT_ERR,
`endif
  input  logic                                I_SA_OUT_VLD,
  input  logic [SA_R*SA_C*D_W-1:0]            I_SA_OUT
);

  localparam int MW = mat_w(SA_R, SA_C, D_W);
  localparam int IW = idx_w(N_REQ);

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, idx_q;
  logic [N_REQ-1:0] gnt_q;
  logic             busy_q;
  logic [MW-1:0]    out_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_vld;
  logic             wd_trip;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IW)) u_arb (
    .req_i (I_REQ),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

`ifdef SA_SCHED_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt_q;
  logic          wd_trip_q, wd_rstn_q, err_q;

  // Trip cycle holds the engine in sync reset; the following cycle retires the job.
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      wd_cnt_q  <= '0;
      wd_trip_q <= 1'b0;
      wd_rstn_q <= 1'b1;
      err_q     <= 1'b0;
    end else if (state_q != S_WAIT) begin
      wd_cnt_q  <= '0;
      wd_trip_q <= 1'b0;
      wd_rstn_q <= 1'b1;
    end else if (wd_trip_q) begin
      wd_trip_q <= 1'b0;
      wd_rstn_q <= 1'b1;
      err_q     <= 1'b1;
    end else if (!I_SA_OUT_VLD) begin
      if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
        wd_trip_q <= 1'b1;
        wd_rstn_q <= 1'b0;
      end else begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
    end
  end

  assign wd_trip        = wd_trip_q;
  assign O_SA_SYNC_RSTN = wd_rstn_q;
  assign O_TIMEOUT_ERR  = err_q;
`else
  assign wd_trip        = 1'b0;
  assign O_SA_SYNC_RSTN = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (arb_vld) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (wd_trip || I_SA_OUT_VLD) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      idx_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (arb_vld) begin
          idx_q  <= arb_idx;
          ptr_q  <= arb_idx;
          gnt_q  <= arb_gnt;
          busy_q <= 1'b1;
        end
        S_WAIT: begin
          if (wd_trip)           out_q <= '0;
          else if (I_SA_OUT_VLD) out_q <= I_SA_OUT;
        end
        S_DONE: begin
          gnt_q  <= '0;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign O_GNT      = gnt_q;
  assign O_BUSY     = busy_q;
  assign O_OUT      = out_q;
  assign O_DONE     = (state_q == S_DONE) ? gnt_q : '0;
  assign O_SA_START = (state_q == S_LAUNCH);

  // Engine sees zeros while idle so a stale slot never leaks onto the array.
  assign O_SA_X_MATRIX = (state_q == S_IDLE) ? '0 : I_X_MATRIX[int'(idx_q)*MW +: MW];
  assign O_SA_W_MATRIX = (state_q == S_IDLE) ? '0 : I_W_MATRIX[int'(idx_q)*MW +: MW];

endmodule

// File: doc/sa_rr_scheduler.md
Name: sa_rr_scheduler

Overview:
- Shares one systolic-array matmul engine (SA_wrapper, D_W x SA_R x SA_C) among N_REQ requesters, e.g. the QK^T, softmax*V and projection engines.
- Grants requesters round-robin and steers the granted requester's X/W matrices onto the engine.
- Issues the one-cycle start pulse, captures the result on the engine's O_OUT_VLD, and returns it with a per-requester done pulse.

Parameters:
- D_W, 16, element width (fixed point)
- SA_R, 16, array rows
- SA_C, 16, array columns
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
- I_CLK  in  1  clock
- I_ASYN_RSTN  in  1  asynchronous active-low reset
- I_REQ  in  N_REQ  per-requester job request, level
- I_X_MATRIX  in  N_REQ*SA_R*SA_C*D_W  packed X matrices; slot i = requester i
- I_W_MATRIX  in  N_REQ*SA_R*SA_C*D_W  packed W matrices; slot i = requester i
- O_GNT  out  N_REQ  one-hot grant, held for the whole job
- O_DONE  out  N_REQ  one-hot one-cycle completion pulse
- O_OUT  out  SA_R*SA_C*D_W  result register, shared bus
- O_BUSY  out  1  job in flight
- O_SA_START  out  1  to engine I_START_FLAG
- O_SA_SYNC_RSTN  out  1  to engine I_SYNC_RSTN
- O_SA_X_MATRIX  out  SA_R*SA_C*D_W  to engine I_X_MATRIX
- O_SA_W_MATRIX  out  SA_R*SA_C*D_W  to engine I_W_MATRIX
- I_SA_OUT_VLD  in  1  from engine O_OUT_VLD
- I_SA_OUT  in  SA_R*SA_C*D_W  from engine O_OUT

Behaviour:
- Reset values: O_GNT=0, O_DONE=0, O_OUT=0, O_BUSY=0, O_SA_START=0, O_SA_SYNC_RSTN=1, rr pointer=N_REQ-1, state=IDLE.
- The O_SA_X/W_MATRIX mux selects slot gnt_idx. While IDLE it drives zeros.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - If |I_REQ, pick the first set bit searching from ptr+1 upward with wrap.
  - Register gnt_idx, O_GNT, O_BUSY=1 and ptr=gnt_idx; go to LAUNCH.
  - Otherwise stay in IDLE.
- LAUNCH: O_SA_START=1 for exactly this cycle; go to WAIT.
- WAIT:
  - On I_SA_OUT_VLD=1, register O_OUT<=I_SA_OUT and go to DONE.
  - I_SA_OUT_VLD seen in any other state is ignored.
- DONE:
  - O_DONE[gnt_idx]=1 for this cycle only; O_OUT stays valid until the next capture.
  - Clear O_GNT and O_BUSY; go to IDLE.
- Latency:
  - REQ sampled at edge k -> GNT/BUSY high after edge k; START high in cycle k+1.
  - VLD sampled at edge m -> O_OUT and O_DONE high in cycle m+1.
  - At least one IDLE cycle separates back-to-back jobs.
- Requester contract: hold I_REQ and its matrix slot stable from request until O_DONE.
  - A requester that drops I_REQ mid-job is not aborted; its done still pulses.
  - A requester that keeps I_REQ high after done is treated as a new request.
- Fairness: a requester waits at most N_REQ-1 jobs. Simultaneous requests are resolved strictly by the rr pointer; index order does not set priority.
- Asynchronous reset mid-job returns all state to reset values immediately; the engine is reset by the same async reset.
- With the optional feature off, O_SA_SYNC_RSTN is tied to 1.

Optional Feature:
- Macro: SA_SCHED_WATCHDOG_EN.
- When defined:
  - A counter runs in WAIT. If it reaches TIMEOUT with no I_SA_OUT_VLD, drive O_SA_SYNC_RSTN=0 for one cycle.
  - Then pulse O_DONE[gnt_idx] with O_OUT forced to 0, and raise sticky output O_TIMEOUT_ERR (1 bit, cleared only by reset).
  - Then go to IDLE with the pointer advanced as normal.
- When undefined: no counter, no O_TIMEOUT_ERR port, and WAIT waits indefinitely.

Decomposition:
- Package sa_sched_pkg holds:
  - the state enum {IDLE, LAUNCH, WAIT, DONE}
  - MAT_W = SA_R*SA_C*D_W
  - IDX_W = $clog2(N_REQ)
- One sub-module, rr_arbiter: combinational, takes req vector and pointer, returns one-hot grant and index. The FSM, muxes and result register stay in the top module.

Test Plan:
- Single job: N_REQ=4, SA stub returns VLD 20 cycles after START with OUT=all 0x1234; I_REQ=4'b0010. Expect GNT=0010 next cycle, one START pulse, O_OUT=0x1234 per element and O_DONE=0010 for one cycle, BUSY low after.
- Round-robin: I_REQ=4'b1111 held. Grant order 0,1,2,3,0; each O_DONE bit pulses once per round; exactly one START per job.
- Wrap and skip: ptr=2, I_REQ=4'b0011. Next grant is 0, then 1; no grant is ever given to an idle requester.
- Mux integrity: slot1 X = rows 0x000..0xF00, slot2 zeros, grant 1. O_SA_X_MATRIX equals slot1 bit-for-bit through WAIT.
- Reset mid-job: assert I_ASYN_RSTN low during WAIT. All outputs go to reset values immediately; after release, a held request is re-granted starting from requester 0.
- Watchdog (SA_SCHED_WATCHDOG_EN, TIMEOUT=64), stub never asserts VLD:
  - SYNC_RSTN pulses low at WAIT+64.
  - O_DONE pulses with O_OUT=0 and O_TIMEOUT_ERR=1.
  - Next requester is then granted normally.
